// File: rtl/gbsha_fir_pkg.sv
// Shared types and width helpers for the gbsha streaming FIR filter.
// Imported by the top level and the scaling stage.
package gbsha_fir_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_e;

    function automatic int fir_acc_width(input int bw_in, input int bw_coef, input int n_taps);
        return bw_in + bw_coef + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/gbsha_fir_round_sat.sv
// Combinational output scaling: round-half-up arithmetic shift, then
// saturation to the signed output range with a clip flag.
module gbsha_fir_round_sat #(
    parameter int BW_ACC = 15,
    parameter int SHIFT  = 0,
    parameter int BW_OUT = 8
) (
    input  logic signed [BW_ACC-1:0] acc,
    output logic signed [BW_OUT-1:0] r,
    output logic                     sat
);

    // One guard bit for the rounding add, one more so the clip bounds always fit.
    localparam int CW     = ((BW_ACC + 1 > BW_OUT) ? BW_ACC + 1 : BW_OUT) + 1;
    localparam int HALF_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

    localparam logic signed [CW-1:0] HALF    = CW'(HALF_I);
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW - BW_OUT + 1){1'b0}}, {(BW_OUT - 1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [CW-1:0] scaled;

    always_comb begin
        scaled = (CW'(acc) + HALF) >>> SHIFT;
        r      = scaled[BW_OUT-1:0];
        sat    = 1'b0;
        if (scaled > SAT_MAX) begin
            r   = SAT_MAX[BW_OUT-1:0];
            sat = 1'b1;
        end else if (scaled < SAT_MIN) begin
            r   = SAT_MIN[BW_OUT-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/gbsha_fir_stream.sv
// Streaming FIR with valid/ready handshakes, run-time coefficient reload and
// rounded, saturating output. Single-cycle MAC feeding a one-deep output register.
module gbsha_fir_stream
    import gbsha_fir_pkg::*;
#(
    parameter int N_TAPS  = 8,
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_OUT  = 8,
    parameter int SHIFT   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     coef_load,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [BW_IN-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [BW_OUT-1:0] out_data,
    output logic                     out_sat,
    output logic                     coef_loaded
);

    localparam int BW_ACC = fir_acc_width(BW_IN, BW_COEF, N_TAPS);
    localparam int CNT_W  = $clog2(N_TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS - 1);

    fir_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [BW_COEF-1:0] coef_q [N_TAPS];
    logic signed [BW_COEF-1:0] coef_d [N_TAPS];
    // Only the N_TAPS-1 older samples are stored; tap 0 is the incoming word.
    logic signed [BW_IN-1:0]   hist_q [N_TAPS-1];
    logic signed [BW_IN-1:0]   hist_d [N_TAPS-1];
    logic                      out_valid_q, out_valid_d;
    logic signed [BW_OUT-1:0]  out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [BW_ACC-1:0]  acc;
    logic signed [BW_OUT-1:0]  r;
    logic                      r_sat;
    logic                      accept;

    always_comb begin
        acc = BW_ACC'(coef_q[0]) * BW_ACC'(in_data);
        for (int unsigned i = 1; i < N_TAPS; i++) begin
            acc = acc + BW_ACC'(coef_q[i]) * BW_ACC'(hist_q[i-1]);
        end
    end

    gbsha_fir_round_sat #(
        .BW_ACC (BW_ACC),
        .SHIFT  (SHIFT),
        .BW_OUT (BW_OUT)
    ) u_round_sat (
        .acc (acc),
        .r   (r),
        .sat (r_sat)
    );

    // reset_n gates in_ready directly so the source sees not-ready during reset.
    always_comb begin
        in_ready = reset_n && !coef_load
                   && ((state_q == ST_LOAD) || !out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coef_d      = coef_q;
        hist_d      = hist_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (coef_load) begin
            state_d     = ST_LOAD;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            for (int unsigned i = 0; i < N_TAPS - 1; i++) begin
                hist_d[i] = '0;
            end
        end else if (state_q == ST_LOAD) begin
            if (accept) begin
                coef_d[0] = BW_COEF'(in_data);
                for (int unsigned i = 1; i < N_TAPS; i++) begin
                    coef_d[i] = coef_q[i-1];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            if (accept) begin
                hist_d[0] = in_data;
                for (int unsigned i = 1; i < N_TAPS - 1; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                out_valid_d = 1'b1;
                out_data_d  = r;
                out_sat_d   = r_sat;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
            for (int unsigned i = 0; i < N_TAPS - 1; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            coef_q      <= coef_d;
            hist_q      <= hist_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign coef_loaded = (state_q == ST_RUN);

endmodule
